// File: rtl/fetch_sequencer.sv
// Program counter and fetch/issue controller for the 8-bit CPU: fetches from a
// combinational instruction memory, issues over valid/ready, resolves JZ and stops on HLT.
module fetch_sequencer #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [7:0]        HLT_WORD  = 8'h00,
    parameter logic [2:0]        JZ_OPCODE = 3'b111,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    output logic [7:0]        instr,
    output logic              instr_valid,
    input  logic              exec_ready,
    input  logic              br_valid,
    input  logic              br_taken,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        RESOLVE = 3'd3,
        HALT    = 3'd4
    } state_t;

    // Handshake: instr is transferred on a rising edge where instr_valid and
    // exec_ready are both high; instr stays stable while instr_valid is high.
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [7:0]         instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                instr_d = imem_data;
                pc_d    = pc_q + ADDR_W'(1);
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (exec_ready) begin
                    valid_d = 1'b0;
                    if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
                    // HLT is checked first so it wins over the JZ opcode field.
                    if (instr_q == HLT_WORD) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else if (instr_q[7:5] == JZ_OPCODE) begin
                        state_d = RESOLVE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            RESOLVE: begin
                if (br_valid) begin
                    if (br_taken) pc_d = ADDR_W'(instr_q[4:0]);
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (start) begin
                    pc_d     = RESET_PC;
                    halted_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign retired     = retired_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: issued instructions are scored against an expected
// queue, with program-level checks of pc, retired and halted.
module tb_fetch_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_RESOLVE = 3'd3;

    logic        clk, rst_n, start, exec_ready, br_valid, br_taken;
    logic [7:0]  imem_addr, imem_data, instr, pc;
    logic        instr_valid, halted;
    logic [15:0] retired;
    logic [2:0]  dbg_state;

    logic [7:0]  mem [256];
    logic [7:0]  exp_q [$];
    bit          take_q [$];
    logic [7:0]  prog [7];
    int          vectors, miscompares, model_ret, br_hold;
    bit          br_auto;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .exec_ready(exec_ready), .br_valid(br_valid), .br_taken(br_taken),
        .pc(pc), .halted(halted), .retired(retired), .dbg_state(dbg_state)
    );

    assign imem_data = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and branch responder: look one half-cycle ahead of each rising edge.
    always begin
        @(negedge clk);
        #1;
        if (br_hold > 0) begin
            br_hold--;
            if (br_hold == 0) begin
                br_valid = 1'b0;
                br_taken = 1'b0;
            end
        end
        if (instr_valid && exec_ready && rst_n) begin
            check("retired_before_hs", retired, model_ret);
            model_ret++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                check("issued_instr", instr, exp_q.pop_front());
            end
            if (br_auto && instr[7:5] == 3'b111 && instr != 8'h00) begin
                br_valid = 1'b1;
                br_taken = (take_q.size() > 0) ? take_q.pop_front() : 1'b0;
                br_hold  = 2;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        exec_ready = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        br_hold = 0;
        model_ret = 0;
        exp_q.delete();
        take_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 7; i++) mem[i] = prog[i];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (halted) done = 1'b1;
        end
        check({tag, "_halt_reached"}, halted, 1'b1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        br_auto = 1'b1;
        prog = '{8'hA2, 8'hAB, 8'h08, 8'hD0, 8'h21, 8'hE2, 8'h00};
        load_prog();

        // Reset values
        rst_n = 1'b0;
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_retired", retired, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;

        // Straight-line run, JZ not taken
        exec_ready = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(prog[i]);
        take_q.push_back(1'b0);
        pulse_start();
        wait_halt("nt");
        check("nt_retired", retired, 7);
        check("nt_pc", pc, 7);
        check("nt_imem_addr", imem_addr, 7);
        check("nt_valid", instr_valid, 0);
        check("nt_sb_empty", exp_q.size(), 0);

        // Restart from HALT keeps retired and refetches from 0
        for (int i = 0; i < 7; i++) exp_q.push_back(prog[i]);
        take_q.push_back(1'b0);
        pulse_start();
        check("rs_halted", halted, 0);
        check("rs_pc", pc, 0);
        check("rs_retired", retired, 7);
        check("rs_state", dbg_state, S_FETCH);
        @(negedge clk);
        check("rs_first_instr", instr, 8'hA2);
        check("rs_first_pc", pc, 1);
        wait_halt("rs");
        check("rs_final_retired", retired, 14);
        check("rs_sb_empty", exp_q.size(), 0);

        // First JZ taken back to address 2, second not taken
        do_reset();
        exec_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(prog[i]);
        for (int i = 2; i < 7; i++) exp_q.push_back(prog[i]);
        take_q.push_back(1'b1);
        take_q.push_back(1'b0);
        pulse_start();
        wait_halt("tk");
        check("tk_retired", retired, 11);
        check("tk_pc", pc, 7);
        check("tk_sb_empty", exp_q.size(), 0);

        // Back-pressure: ISSUE holds A2 while exec_ready is low
        do_reset();
        pulse_start();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instr, 8'hA2);
            check("stall_pc", pc, 1);
            check("stall_retired", retired, 0);
        end
        exp_q.push_back(8'hA2);
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        check("stall_rel_retired", retired, 1);
        check("stall_rel_valid", instr_valid, 0);
        check("stall_rel_state", dbg_state, S_FETCH);
        check("stall_sb_empty", exp_q.size(), 0);

        // Asynchronous reset in RESOLVE; later br_valid is ignored
        do_reset();
        br_auto = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[0] = 8'hE5;
        exp_q.push_back(8'hE5);
        exec_ready = 1'b1;
        pulse_start();
        begin
            bit got_res;
            got_res = 1'b0;
            for (int i = 0; i < 20 && !got_res; i++) begin
                @(negedge clk);
                if (dbg_state == S_RESOLVE) got_res = 1'b1;
            end
            check("ar_reached_resolve", got_res, 1);
        end
        exec_ready = 1'b0;
        check("ar_pre_pc", pc, 1);
        check("ar_pre_retired", retired, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_pc", pc, 0);
        check("ar_instr", instr, 0);
        check("ar_retired", retired, 0);
        check("ar_halted", halted, 0);
        check("ar_state", dbg_state, S_IDLE);
        #1 rst_n = 1'b1;
        @(negedge clk);
        br_valid = 1'b1;
        br_taken = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_br_ignored_pc", pc, 0);
        check("ar_br_ignored_state", dbg_state, S_IDLE);
        check("ar_br_ignored_valid", instr_valid, 0);
        br_valid = 1'b0;
        br_taken = 1'b0;
        br_auto = 1'b1;

        // PC wrap from 255 to 0
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[0] = 8'h03;
        mem[255] = 8'h02;
        exp_q.push_back(8'h03);
        for (int i = 1; i < 255; i++) exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exec_ready = 1'b1;
        pulse_start();
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 1000 && !found; i++) begin
                @(negedge clk);
                if (instr_valid && instr == 8'h02) found = 1'b1;
            end
            check("wrap_seen_255", found, 1);
        end
        check("wrap_pc", pc, 0);
        @(negedge clk);
        @(negedge clk);
        exec_ready = 1'b0;
        check("wrap_refetch_instr", instr, 8'h03);
        check("wrap_refetch_pc", pc, 1);
        check("wrap_refetch_valid", instr_valid, 1);
        check("wrap_retired", retired, 256);
        check("wrap_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
